// File: rtl/washer_pkg.sv
// Shared washer definitions: beep sequencer state encoding and default timing constants.
package washer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } beepState_e;

  // 1 ms tick at a 50 MHz system clock.
  localparam int TICK_DIV_1MS = 50000;
  localparam int BEEP_ON_DEF  = 200;
  localparam int BEEP_OFF_DEF = 200;
  localparam int BEEP_CNT_W   = 4;
  localparam int TONE_DIV_DEF = 25000;

endpackage

// File: rtl/beep_sequencer_if.sv
// Request/status bundle between the controllers and the beep sequencer.
interface beep_sequencer_if
  import washer_pkg::*;
#(
  parameter int CNT_W = BEEP_CNT_W
);

  logic             req;
  logic [CNT_W-1:0] count;
  logic             abort;
  logic             bee;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

  modport master (
    output req, count, abort,
    input  bee, busy, done, remaining
  );

  modport slave (
    input  req, count, abort,
    output bee, busy, done, remaining
  );

endinterface

// File: rtl/beep_sequencer_tick_prescaler.sv
// Free-running clock divider: one-cycle tick every TICK_DIV clocks, restartable via clr.
module tick_prescaler
  import washer_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_1MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);

  logic [W-1:0] cnt;

  // Decoded from the counter only, so clr may safely depend on tick.
  assign tick = (cnt == W'(TICK_DIV - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/beep_sequencer.sv
// Beep sequencer: turns a one-cycle request carrying a count into timed ON/OFF beeps.
// Optional BEEP_TONE_EN: bee toggles every TONE_DIV cycles during ON to drive a passive piezo.
module beep_sequencer
  import washer_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_1MS,
  parameter int ON_TICKS  = BEEP_ON_DEF,
  parameter int OFF_TICKS = BEEP_OFF_DEF,
  parameter int CNT_W     = BEEP_CNT_W,
  parameter int TONE_DIV  = TONE_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  beep_sequencer_if.slave  bus
);

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);

  beepState_e       state, stateNext;
  logic [CNT_W-1:0] remaining, remainingNext;
  logic [TW-1:0]    tickCnt, tickCntNext;
  logic             done, doneNext;
  logic             bee, beeNext;
  logic             busy;
  logic             tick;
  logic             prescClr;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) uPrescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (prescClr),
    .tick  (tick)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext     = state;
    remainingNext = remaining;
    tickCntNext   = tick ? tickCnt + 1'b1 : tickCnt;
    doneNext      = 1'b0;
    prescClr      = 1'b0;

    case (state)
      IDLE: begin
        // Timebase held at zero so the first ON phase starts exactly on entry.
        prescClr    = 1'b1;
        tickCntNext = '0;
        if (bus.req && (bus.count != '0)) begin
          stateNext     = ON;
          remainingNext = bus.count;
        end
      end
      ON: begin
        if (tick && (tickCnt == TW'(ON_TICKS - 1))) begin
          prescClr    = 1'b1;
          tickCntNext = '0;
          if (remaining > CNT_W'(1)) begin
            remainingNext = remaining - 1'b1;
            stateNext     = OFF;
          end else begin
            remainingNext = '0;
            stateNext     = IDLE;
            doneNext      = 1'b1;
          end
        end
      end
      OFF: begin
        if (tick && (tickCnt == TW'(OFF_TICKS - 1))) begin
          prescClr    = 1'b1;
          tickCntNext = '0;
          stateNext   = ON;
        end
      end
      default: begin
        stateNext     = IDLE;
        remainingNext = '0;
      end
    endcase

    // Abort overrides everything, including a simultaneous request.
    if (bus.abort) begin
      stateNext     = IDLE;
      remainingNext = '0;
      doneNext      = 1'b0;
      prescClr      = 1'b1;
      tickCntNext   = '0;
    end
  end

`ifdef BEEP_TONE_EN
  localparam int TONEW = $clog2(TONE_DIV + 1);

  logic [TONEW-1:0] toneCnt;
  logic             toneWrap;
  logic             onEntry;

  assign toneWrap = (toneCnt == TONEW'(TONE_DIV - 1));
  assign onEntry  = (stateNext == ON) && (state != ON);

  always_comb begin
    beeNext = 1'b0;
    if (stateNext == ON) begin
      if (onEntry)       beeNext = 1'b1;
      else if (toneWrap) beeNext = ~bee;
      else               beeNext = bee;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toneCnt <= '0;
    end else if ((stateNext != ON) || onEntry || toneWrap) begin
      toneCnt <= '0;
    end else begin
      toneCnt <= toneCnt + 1'b1;
    end
  end
`else
  always_comb begin
    beeNext = (stateNext == ON);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      tickCnt   <= '0;
      done      <= 1'b0;
      bee       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= stateNext;
      remaining <= remainingNext;
      tickCnt   <= tickCntNext;
      done      <= doneNext;
      bee       <= beeNext;
      busy      <= (stateNext != IDLE);
    end
  end

  assign bus.bee       = bee;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.remaining = remaining;

endmodule

// File: tb/tb_beep_sequencer.sv
// Scoreboard bench for beep_sequencer: a timeline model predicts every cycle's outputs.
module tb_beep_sequencer;
  import washer_pkg::*;

  localparam int TICK_DIV  = 4;
  localparam int ON_TICKS  = 3;
  localparam int OFF_TICKS = 2;
  localparam int CNT_W     = 4;
  localparam int TONE_DIV  = 2;
  localparam int ON_CYC    = ON_TICKS * TICK_DIV;
  localparam int OFF_CYC   = OFF_TICKS * TICK_DIV;
  localparam int PERIOD    = ON_CYC + OFF_CYC;

  typedef struct {
    logic             bee;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] rem;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  beep_sequencer_if #(.CNT_W(CNT_W)) bus ();

  beep_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .ON_TICKS  (ON_TICKS),
    .OFF_TICKS (OFF_TICKS),
    .CNT_W     (CNT_W),
    .TONE_DIV  (TONE_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t expQ[$];

  // Reference timeline: sequence start edge, beep count and overall length in cycles.
  bit mActive = 1'b0;
  int mStart  = 0;
  int mCount  = 0;
  int mTotal  = 0;
  int cycNum  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic modelEdge(input logic r, input logic [CNT_W-1:0] c, input logic a);
    exp_t e;
    int   k;
    int   idx;
    int   pos;
    e = '{default: '0};
    cycNum++;
    if (a) begin
      mActive = 1'b0;
    end else if (mActive) begin
      k = cycNum - mStart + 1;
      if (k > mTotal) begin
        mActive = 1'b0;
        e.done  = 1'b1;
      end
    end else if (r && (c != '0)) begin
      mActive = 1'b1;
      mStart  = cycNum;
      mCount  = int'(c);
      mTotal  = mCount * ON_CYC + (mCount - 1) * OFF_CYC;
    end
    if (mActive) begin
      k      = cycNum - mStart + 1;
      idx    = (k - 1) / PERIOD;
      pos    = (k - 1) % PERIOD;
      e.busy = 1'b1;
      e.rem  = CNT_W'(mCount - idx - ((pos >= ON_CYC) ? 1 : 0));
`ifdef BEEP_TONE_EN
      e.bee  = (pos < ON_CYC) && (((pos / TONE_DIV) % 2) == 0);
`else
      e.bee  = (pos < ON_CYC);
`endif
    end
    expQ.push_back(e);
  endtask

  // Drive one cycle's inputs, let the edge sample them, and queue the predicted outputs.
  task automatic cyc1(input logic r, input logic [CNT_W-1:0] c, input logic a);
    bus.req   = r;
    bus.count = c;
    bus.abort = a;
    @(posedge clk);
    modelEdge(r, c, a);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc1(1'b0, '0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".bee"}, int'(bus.bee), 0);
    check({tag, ".busy"}, int'(bus.busy), 0);
    check({tag, ".done"}, int'(bus.done), 0);
    check({tag, ".remaining"}, int'(bus.remaining), 0);
  endtask

  // Monitor: compares whatever prediction is pending, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      check("bee", int'(bus.bee), int'(e.bee));
      check("busy", int'(bus.busy), int'(e.busy));
      check("done", int'(bus.done), int'(e.done));
      check("remaining", int'(bus.remaining), int'(e.rem));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req   = 1'b0;
    bus.count = '0;
    bus.abort = 1'b0;
    #12;
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);

    // Single beep, with a second request mid-run that must be ignored.
    cyc1(1'b1, CNT_W'(1), 1'b0);
    idle(4);
    cyc1(1'b1, CNT_W'(5), 1'b0);
    idle(12);

    // Two beeps.
    cyc1(1'b1, CNT_W'(2), 1'b0);
    idle(38);

    // Zero-count request is ignored.
    cyc1(1'b1, CNT_W'(0), 1'b0);
    idle(5);

    // Abort during the OFF gap of a three-beep run.
    cyc1(1'b1, CNT_W'(3), 1'b0);
    idle(14);
    cyc1(1'b0, '0, 1'b1);
    idle(6);

    // Abort together with a request in IDLE.
    cyc1(1'b1, CNT_W'(2), 1'b1);
    idle(4);

    // Back-to-back: request on the done cycle is accepted.
    cyc1(1'b1, CNT_W'(1), 1'b0);
    idle(12);
    cyc1(1'b1, CNT_W'(1), 1'b0);
    idle(14);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cyc1(($urandom_range(0, 9) == 0), CNT_W'($urandom_range(0, 3)),
           ($urandom_range(0, 99) == 0));
    end
    idle(70);

    // Asynchronous reset in the middle of an ON phase.
    cyc1(1'b1, CNT_W'(2), 1'b0);
    idle(5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("asyncReset");
    mActive = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(10);

    @(negedge clk);
    #1;
    check("queueDrained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
